// File: rtl/three_to_eight_dec.sv
// three_to_eight_dec
// Registered 3-to-8 decoder with decode enable and selectable output polarity.
// A and en are sampled on the rising clk edge. Exactly one of H..O is asserted
// one cycle later, and valid marks a decoded code. OUT_ACTIVE_LOW selects
// whether the asserted level is 1 (default) or 0. valid is always active-high.
// Optional build macro THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN adds a registered
// err output. It flags output patterns that are neither idle nor one-hot.
module three_to_eight_dec #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] A,
  output logic       H,
  output logic       I,
  output logic       J,
  output logic       K,
  output logic       L,
  output logic       M,
  output logic       N,
  output logic       O,
  output logic       valid
`ifdef THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN
  ,
  output logic       err
`endif
);

  // Output level pattern with every line deasserted.
  localparam logic [7:0] IDLE_LEVEL = {8{OUT_ACTIVE_LOW}};

  // Active-high one-hot image of a 3-bit code. Bit n is set for code n.
  function automatic logic [7:0] decode(input logic [2:0] code);
    logic [7:0] r;
    r       = 8'd0;
    r[code] = 1'b1;
    return r;
  endfunction

  // Map between active-high and pin levels. The mapping is its own inverse,
  // so the same function also normalises pin levels back to active-high.
  function automatic logic [7:0] to_level(input logic [7:0] v);
    return OUT_ACTIVE_LOW ? ~v : v;
  endfunction

  // True when at most one bit is set (idle or one-hot).
  function automatic logic is_onehot0(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

  logic [7:0] lines_p0;
  logic       vld_p0;

  // Stage p0: sample A/en. Store the decoded lines at their pin level.
  // Reset clears the lines to idle and drops valid, overriding en and A.
  always_ff @(posedge clk) begin
    if (rst) begin
      lines_p0 <= IDLE_LEVEL;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0   <= en;
      lines_p0 <= en ? to_level(decode(A)) : IDLE_LEVEL;
    end
  end

  assign H     = lines_p0[0];
  assign I     = lines_p0[1];
  assign J     = lines_p0[2];
  assign K     = lines_p0[3];
  assign L     = lines_p0[4];
  assign M     = lines_p0[5];
  assign N     = lines_p0[6];
  assign O     = lines_p0[7];
  assign valid = vld_p0;

`ifdef THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN
  logic err_p1;

  // Stage p1: check the registered output lines after normalising them to
  // active-high. err follows the condition and clears once the lines are legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= !is_onehot0(to_level(lines_p0));
    end
  end

  assign err = err_p1;
`endif

endmodule

// File: tb/tb_three_to_eight_dec.sv
// Scoreboard bench for three_to_eight_dec. The bench drives one default-
// polarity instance and one active-low instance with the same inputs. Each
// vector carries its expected active-high line pattern and valid bit. The
// monitor checks both instances one cycle after the vector is applied.
module tb_three_to_eight_dec;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] a;

  logic h0, i0, j0, k0, l0, m0, n0, o0, valid0;
  logic h1, i1, j1, k1, l1, m1, n1, o1, valid1;
`ifdef THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN
  logic err0, err1;
`endif

  three_to_eight_dec #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .A(a),
    .H(h0), .I(i0), .J(j0), .K(k0), .L(l0), .M(m0), .N(n0), .O(o0),
    .valid(valid0)
`ifdef THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN
    , .err(err0)
`endif
  );

  three_to_eight_dec #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .A(a),
    .H(h1), .I(i1), .J(j1), .K(k1), .L(l1), .M(m1), .N(n1), .O(o1),
    .valid(valid1)
`ifdef THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN
    , .err(err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lines;
    logic       vld;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Apply one vector before the next rising edge and queue its expected response.
  task automatic vec(input logic r, input logic e, input logic [2:0] code,
                     input logic [7:0] exp_lines, input logic exp_vld);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    a   = code;
    x.lines = exp_lines;
    x.vld   = exp_vld;
    exp_q.push_back(x);
  endtask

  // Monitor: after each rising edge, pop one expectation and compare both instances.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("lines_hi", {o0, n0, m0, l0, k0, j0, i0, h0}, x.lines);
        check("valid_hi", {7'd0, valid0}, {7'd0, x.vld});
        check("lines_lo", {o1, n1, m1, l1, k1, j1, i1, h1}, ~x.lines);
        check("valid_lo", {7'd0, valid1}, {7'd0, x.vld});
`ifdef THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN
        check("err_hi", {7'd0, err0}, 8'd0);
        check("err_lo", {7'd0, err1}, 8'd0);
`endif
      end
    end
  end

  // Directed stimulus with hand-computed expectations (active-high lines).
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = 3'd0;
    // Reset held two cycles with en=1, A=5: idle lines, valid low.
    vec(1'b1, 1'b1, 3'd5, 8'b0000_0000, 1'b0);
    vec(1'b1, 1'b1, 3'd5, 8'b0000_0000, 1'b0);
    // Full sweep A=0..7: H..O in turn, back to back.
    vec(1'b0, 1'b1, 3'd0, 8'b0000_0001, 1'b1);
    vec(1'b0, 1'b1, 3'd1, 8'b0000_0010, 1'b1);
    vec(1'b0, 1'b1, 3'd2, 8'b0000_0100, 1'b1);
    vec(1'b0, 1'b1, 3'd3, 8'b0000_1000, 1'b1);
    vec(1'b0, 1'b1, 3'd4, 8'b0001_0000, 1'b1);
    vec(1'b0, 1'b1, 3'd5, 8'b0010_0000, 1'b1);
    vec(1'b0, 1'b1, 3'd6, 8'b0100_0000, 1'b1);
    vec(1'b0, 1'b1, 3'd7, 8'b1000_0000, 1'b1);
    // Enable gating at A=3: en 1,0,1.
    vec(1'b0, 1'b1, 3'd3, 8'b0000_1000, 1'b1);
    vec(1'b0, 1'b0, 3'd3, 8'b0000_0000, 1'b0);
    vec(1'b0, 1'b1, 3'd3, 8'b0000_1000, 1'b1);
    // A=6, which gives N=0 with the others at 1 on the active-low instance.
    vec(1'b0, 1'b1, 3'd6, 8'b0100_0000, 1'b1);
    // Mid-stream reset while A=7 is decoding.
    vec(1'b0, 1'b1, 3'd7, 8'b1000_0000, 1'b1);
    vec(1'b1, 1'b1, 3'd7, 8'b0000_0000, 1'b0);
    vec(1'b0, 1'b1, 3'd7, 8'b1000_0000, 1'b1);
    // Reverse-order changes, then disable.
    vec(1'b0, 1'b1, 3'd1, 8'b0000_0010, 1'b1);
    vec(1'b0, 1'b1, 3'd0, 8'b0000_0001, 1'b1);
    vec(1'b0, 1'b0, 3'd5, 8'b0000_0000, 1'b0);
    stim_done = 1'b1;
  end

  // Finish once the scoreboard drains. A bounded wait counts leftovers as failures.
  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/three_to_eight_dec.md
THREE_TO_EIGHT_DEC -- requirements
Module: three_to_eight_dec

Interface
REQ-001 Parameter OUT_ACTIVE_LOW, default 0: 0 = asserted output is 1; 1 = asserted output is 0 on H..O.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  decode enable, sampled on rising clk.
REQ-005 A  input  3  binary code to decode; bit 2 is MSB.
REQ-006 H  output  1  asserted when registered code = 0.
REQ-007 I  output  1  asserted when registered code = 1.
REQ-008 J  output  1  asserted when registered code = 2.
REQ-009 K  output  1  asserted when registered code = 3.
REQ-010 L  output  1  asserted when registered code = 4.
REQ-011 M  output  1  asserted when registered code = 5.
REQ-012 N  output  1  asserted when registered code = 6.
REQ-013 O  output  1  asserted when registered code = 7.
REQ-014 valid  output  1  high when H..O reflect a decoded code.

Function
REQ-015 Outputs H..O and valid SHALL be registered; latency from A/en sample to output is exactly 1 clk cycle.
REQ-016 With en=1 at a rising edge, exactly one of H..O SHALL be asserted next cycle, selected by A per REQ-006..REQ-013.
REQ-016 applies in all cases: valid=1 next cycle.
REQ-017 With en=0 at a rising edge, all of H..O SHALL be deasserted next cycle, and valid=0.
REQ-018 Asserted/deasserted levels SHALL follow OUT_ACTIVE_LOW. With OUT_ACTIVE_LOW=1, deasserted = 1 and the asserted line = 0.
REQ-019 valid SHALL always be active-high, independent of OUT_ACTIVE_LOW.
REQ-020 Back-to-back code changes SHALL be tracked every cycle with no holdover: the previous line deasserts in the same cycle the new line asserts.
REQ-021 A containing X/Z is outside the supported operating range. No output behaviour is defined for it.
REQ-022 Outputs SHALL never show more than one asserted line.

Reset
REQ-023 On a rising clk edge with rst=1, H..O SHALL go to the deasserted level and valid SHALL go to 0. rst SHALL take priority over en and A.
REQ-024 The first decode after reset SHALL appear one cycle after the first edge with rst=0 and en=1.
REQ-025 Reset asserted mid-stream SHALL clear the outputs at the next edge, discarding the in-flight code.

Configuration
REQ-026 Macro THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN, when defined, SHALL add output err (1 bit, registered).
REQ-026 err behaviour: it asserts one cycle after H..O, normalized to active-high, are neither all-zero nor one-hot.
REQ-026 reset and clearing: err resets to 0 and clears when the condition clears.
REQ-027 Without THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN, the err port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset test: rst=1 for 2 cycles with en=1, A=5 -> H..O all 0, valid=0 (OUT_ACTIVE_LOW=0).
REQ-029 Exhaustive sweep: en=1, A=0..7 on successive cycles -> next cycle H,I,J,K,L,M,N,O asserted respectively, one-hot, valid=1.
REQ-030 Enable gating: A=3, en toggles 1,0,1 -> K=1/valid=1, then all 0/valid=0, then K=1/valid=1, each with 1-cycle latency.
REQ-031 Active-low build: OUT_ACTIVE_LOW=1, en=1, A=6 -> N=0, others 1, valid=1; after rst -> all 1, valid=0.
REQ-032 Mid-stream reset: A=7 decoding, rst pulsed 1 cycle -> O deasserted at that edge, decoding resumes the cycle after rst drops.
REQ-033 Check build: THREE_TO_EIGHT_DEC_ONEHOT_CHECK_EN defined, full sweep of REQ-029 -> err stays 0 throughout.
